read_sched: RTL and testbench
=============================

READ_SCHED -- requirements
Module: read_sched

Interface
REQ-001 SHALL have parameter SIZE, default 8, data word width.
REQ-002 SHALL have parameter STRICT, default 1; 1 = strict bank alternation, 0 = serve any valid bank.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port status_vld, input, 2, per-bank "word written, unread" flags from the write side.
REQ-006 SHALL have port r_data, input, SIZE, RAM read data; valid one cycle after r_en.
REQ-007 SHALL have port dout_rdy, input, 1, downstream ready.
REQ-008 SHALL have port r_addr, output, 1, RAM read bank select.
REQ-009 SHALL have port r_en, output, 1, RAM read strobe.
REQ-010 SHALL have port dout, output, SIZE, word delivered downstream.
REQ-011 SHALL have port dout_vld, output, 1, dout valid.
REQ-012 SHALL have port r_done, output, 2, per-bank release to the write side; one-hot or zero.
REQ-013 SHALL have port rd_cnt, output, 8, count of completed reads.

Function
REQ-014 SHALL implement FSM states IDLE, RD, WAIT, OUT, REL.
REQ-015 SHALL keep 1-bit rd_ptr, the bank expected next.
REQ-016 IDLE, STRICT=1: status_vld[rd_ptr]=1 -> RD with bank=rd_ptr; otherwise stay in IDLE, even if the other bank is valid.
REQ-017 IDLE, STRICT=0: bank=rd_ptr if status_vld[rd_ptr]=1, else ~rd_ptr if status_vld[~rd_ptr]=1, else stay in IDLE.
REQ-018 RD: r_en=1 and r_addr=bank for exactly one cycle; then WAIT.
REQ-019 WAIT: capture r_data into dout at the end of the cycle; dout_vld=1 from the next cycle; go to OUT.
REQ-020 OUT: hold dout and dout_vld stable until dout_rdy=1; a transfer occurs on a cycle with dout_vld=1 and dout_rdy=1; then REL.
REQ-021 dout_vld SHALL drop the cycle after the transfer; dout SHALL retain its last value.
REQ-022 REL: r_done[bank]=1, other bit 0; held every cycle until status_vld[bank]=0 is sampled.
- Covers a write side that ignores r_done while it is accepting a write.
REQ-023 On leaving REL: r_done=0, rd_ptr=~bank, rd_cnt+1 (8-bit wrap, 255 -> 0), go to IDLE.
REQ-024 Read-to-read minimum SHALL be 5 cycles (RD, WAIT, OUT with dout_rdy already high, REL for 1 cycle, IDLE).
REQ-025 r_addr SHALL hold bank from RD until the next IDLE exit; r_en=0 in every state except RD.
REQ-026 status_vld of the active bank dropping before REL SHALL NOT abort the read; the FSM completes normally.
REQ-027 Both status_vld bits set in IDLE SHALL serve rd_ptr first, in both modes.
REQ-028 dout_rdy SHALL be ignored outside OUT.

Reset
REQ-029 rst=1 SHALL asynchronously force IDLE, rd_ptr=0, r_addr=0, r_en=0, dout=0, dout_vld=0, r_done=00, rd_cnt=0, in any state including mid-read.
REQ-030 After rst deasserts, the first read SHALL start no earlier than the first rising edge with rst=0.

Verification
REQ-031 Reset, then status_vld=01, r_data=8'hA5, dout_rdy=1 -> r_en pulse with r_addr=0; dout=A5, dout_vld=1 for 1 cycle; r_done=01 until status_vld[0]=0; rd_cnt=1; rd_ptr=1.
REQ-032 STRICT=1, rd_ptr=1, status_vld=01 for 20 cycles -> r_en stays 0; set status_vld=11 -> bank 1 read first.
REQ-033 STRICT=0, rd_ptr=1, status_vld=01 -> bank 0 read; after release rd_ptr=1.
REQ-034 dout_rdy=0 for 10 cycles in OUT -> dout and dout_vld stable; dout_rdy=1 -> single transfer, then r_done asserted.
REQ-035 In REL, status_vld[bank] held at 1 for 6 cycles -> r_done held 6+ cycles; no rd_cnt change until release.
REQ-036 256 back-to-back reads -> rd_cnt wraps to 0; rst pulse in WAIT -> all outputs 0 in the same cycle, no r_done emitted.

Source files
------------

// File: rtl/read_sched.sv
// rtl/read_sched.sv - two-bank ping-pong RAM read scheduler with per-bank release handshake
module read_sched #(
    parameter int SIZE   = 8,
    parameter bit STRICT = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      status_vld,
    input  logic [SIZE-1:0] r_data,
    input  logic            dout_rdy,
    output logic            r_addr,
    output logic            r_en,
    output logic [SIZE-1:0] dout,
    output logic            dout_vld,
    output logic [1:0]      r_done,
    output logic [7:0]      rd_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_OUT,
        ST_REL
    } state_t;

    state_t          state_q, state_d;
    logic            rd_ptr_q, rd_ptr_d;
    logic            bank_q, bank_d;
    logic [SIZE-1:0] dout_q, dout_d;
    logic            dout_vld_q, dout_vld_d;
    logic [7:0]      rd_cnt_q, rd_cnt_d;
    logic            other_bank;

    assign other_bank = ~rd_ptr_q;

    // State and datapath registers; reset may land in the middle of any read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rd_ptr_q   <= 1'b0;
            bank_q     <= 1'b0;
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
            rd_cnt_q   <= 8'd0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            bank_q     <= bank_d;
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
            rd_cnt_q   <= rd_cnt_d;
        end
    end

    // Next-state logic: pick a bank, read it, present the word, then hold release until the writer clears it
    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        bank_d     = bank_q;
        dout_d     = dout_q;
        dout_vld_d = dout_vld_q;
        rd_cnt_d   = rd_cnt_q;
        case (state_q)
            ST_IDLE: begin
                // The expected bank always wins, so both-valid serves rd_ptr first in either mode
                if (status_vld[rd_ptr_q]) begin
                    bank_d  = rd_ptr_q;
                    state_d = ST_RD;
                end else if (!STRICT && status_vld[other_bank]) begin
                    bank_d  = other_bank;
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                dout_d     = r_data;
                dout_vld_d = 1'b1;
                state_d    = ST_OUT;
            end
            ST_OUT: begin
                if (dout_rdy) begin
                    dout_vld_d = 1'b0;
                    state_d    = ST_REL;
                end
            end
            ST_REL: begin
                // The writer may ignore r_done while busy, so keep it up until its flag is seen low
                if (!status_vld[bank_q]) begin
                    rd_ptr_d = ~bank_q;
                    rd_cnt_d = rd_cnt_q + 8'd1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign r_en     = (state_q == ST_RD);
    assign r_addr   = bank_q;
    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign r_done   = (state_q == ST_REL) ? (bank_q ? 2'b10 : 2'b01) : 2'b00;
    assign rd_cnt   = rd_cnt_q;

endmodule

// File: tb/tb_read_sched.sv
// tb/tb_read_sched.sv - directed self-checking bench for read_sched in strict and non-strict modes
module tb_read_sched;

    logic       clk = 1'b0;
    logic       rst;

    logic [1:0] sa, sb;
    logic [7:0] rda, rdb;
    logic       rdy_a, rdy_b;
    logic       r_addr_a, r_en_a, dout_vld_a;
    logic       r_addr_b, r_en_b, dout_vld_b;
    logic [7:0] dout_a, dout_b, rd_cnt_a, rd_cnt_b;
    logic [1:0] r_done_a, r_done_b;

    int n_checks = 0;
    int n_fails  = 0;
    int pulses;
    int bad_alt;

    always #5 clk = ~clk;

    read_sched #(.SIZE(8), .STRICT(1'b1)) u_strict (
        .clk(clk), .rst(rst), .status_vld(sa), .r_data(rda), .dout_rdy(rdy_a),
        .r_addr(r_addr_a), .r_en(r_en_a), .dout(dout_a), .dout_vld(dout_vld_a),
        .r_done(r_done_a), .rd_cnt(rd_cnt_a)
    );

    read_sched #(.SIZE(8), .STRICT(1'b0)) u_loose (
        .clk(clk), .rst(rst), .status_vld(sb), .r_data(rdb), .dout_rdy(rdy_b),
        .r_addr(r_addr_b), .r_en(r_en_b), .dout(dout_b), .dout_vld(dout_vld_b),
        .r_done(r_done_b), .rd_cnt(rd_cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a_zero(input string tag);
        chk({tag, " r_addr"},   32'(r_addr_a),   32'd0);
        chk({tag, " r_en"},     32'(r_en_a),     32'd0);
        chk({tag, " dout"},     32'(dout_a),     32'd0);
        chk({tag, " dout_vld"}, 32'(dout_vld_a), 32'd0);
        chk({tag, " r_done"},   32'(r_done_a),   32'd0);
        chk({tag, " rd_cnt"},   32'(rd_cnt_a),   32'd0);
    endtask

    initial begin
        rst = 1'b1;
        sa = 2'b00; sb = 2'b00;
        rda = 8'h00; rdb = 8'h00;
        rdy_a = 1'b0; rdy_b = 1'b0;
        #12;
        chk_a_zero("reset");
        chk("reset b r_done", 32'(r_done_b), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Non-strict: read bank 0, then with rd_ptr=1 and only bank 0 valid it still serves bank 0
        sb = 2'b01; rdb = 8'h11; rdy_b = 1'b1;
        step();
        chk("b1 r_en", 32'(r_en_b), 32'd1);
        chk("b1 r_addr", 32'(r_addr_b), 32'd0);
        step(); step();
        chk("b1 dout", 32'(dout_b), 32'h11);
        chk("b1 dout_vld", 32'(dout_vld_b), 32'd1);
        step();
        chk("b1 r_done", 32'(r_done_b), 32'd1);
        sb = 2'b00;
        step();
        chk("b1 rd_cnt", 32'(rd_cnt_b), 32'd1);
        chk("b1 r_done off", 32'(r_done_b), 32'd0);
        sb = 2'b01; rdb = 8'h22;
        step();
        chk("b2 r_en", 32'(r_en_b), 32'd1);
        chk("b2 r_addr other bank", 32'(r_addr_b), 32'd0);
        step(); step(); step();
        chk("b2 r_done", 32'(r_done_b), 32'd1);
        sb = 2'b00;
        step();
        chk("b2 rd_cnt", 32'(rd_cnt_b), 32'd2);
        sb = 2'b11;
        step();
        chk("b3 r_en", 32'(r_en_b), 32'd1);
        chk("b3 r_addr rd_ptr kept 1", 32'(r_addr_b), 32'd1);
        sb = 2'b00;
        step(); step(); step();
        chk("b3 r_done", 32'(r_done_b), 32'd2);
        step();
        chk("b3 rd_cnt", 32'(rd_cnt_b), 32'd3);
        chk("a idle during b", 32'(rd_cnt_a), 32'd0);

        // Strict: basic read of bank 0
        sa = 2'b01; rda = 8'hA5; rdy_a = 1'b1;
        step();
        chk("a1 r_en", 32'(r_en_a), 32'd1);
        chk("a1 r_addr", 32'(r_addr_a), 32'd0);
        step();
        chk("a1 wait r_en", 32'(r_en_a), 32'd0);
        chk("a1 wait dout_vld", 32'(dout_vld_a), 32'd0);
        step();
        chk("a1 dout", 32'(dout_a), 32'hA5);
        chk("a1 dout_vld", 32'(dout_vld_a), 32'd1);
        step();
        chk("a1 dout_vld drop", 32'(dout_vld_a), 32'd0);
        chk("a1 dout kept", 32'(dout_a), 32'hA5);
        chk("a1 r_done", 32'(r_done_a), 32'd1);
        step();
        chk("a1 r_done held", 32'(r_done_a), 32'd1);
        chk("a1 rd_cnt before release", 32'(rd_cnt_a), 32'd0);
        sa = 2'b00;
        step();
        chk("a1 r_done released", 32'(r_done_a), 32'd0);
        chk("a1 rd_cnt", 32'(rd_cnt_a), 32'd1);

        // Strict: rd_ptr=1, only bank 0 valid -> no read
        sa = 2'b01;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("a strict hold r_en", 32'(r_en_a), 32'd0);
        end

        // Both valid -> bank 1 first; then backpressure and a slow release
        sa = 2'b11; rda = 8'h3C; rdy_a = 1'b0;
        step();
        chk("a2 r_en", 32'(r_en_a), 32'd1);
        chk("a2 r_addr", 32'(r_addr_a), 32'd1);
        step(); step();
        chk("a2 dout", 32'(dout_a), 32'h3C);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("a2 stall dout", 32'(dout_a), 32'h3C);
            chk("a2 stall dout_vld", 32'(dout_vld_a), 32'd1);
            chk("a2 stall r_done", 32'(r_done_a), 32'd0);
        end
        rdy_a = 1'b1;
        step();
        chk("a2 xfer dout_vld", 32'(dout_vld_a), 32'd0);
        chk("a2 r_done", 32'(r_done_a), 32'd2);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("a2 r_done held", 32'(r_done_a), 32'd2);
            chk("a2 rd_cnt held", 32'(rd_cnt_a), 32'd1);
        end
        sa = 2'b00;
        step();
        chk("a2 r_done released", 32'(r_done_a), 32'd0);
        chk("a2 rd_cnt", 32'(rd_cnt_a), 32'd2);
        chk("a2 r_addr held", 32'(r_addr_a), 32'd1);
        chk("a2 r_en idle", 32'(r_en_a), 32'd0);

        // 256 back-to-back reads from reset; writer clears each bank as soon as it is released
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sa = 2'b11; rda = 8'h77; rdy_a = 1'b1;
        pulses = 0; bad_alt = 0;
        for (int i = 0; i < 1280; i++) begin
            step();
            if (r_en_a) begin
                if (r_addr_a !== pulses[0]) bad_alt++;
                pulses++;
            end
            sa = 2'b11 & ~r_done_a;
        end
        chk("wrap r_en pulses", 32'(pulses), 32'd256);
        chk("wrap bank alternation errors", 32'(bad_alt), 32'd0);
        chk("wrap rd_cnt", 32'(rd_cnt_a), 32'd0);
        rda = 8'h5A;
        for (int i = 0; i < 5; i++) begin
            step();
            sa = 2'b11 & ~r_done_a;
        end
        chk("post wrap rd_cnt", 32'(rd_cnt_a), 32'd1);
        chk("post wrap dout", 32'(dout_a), 32'h5A);

        // Reset asserted while in WAIT clears everything immediately
        step();
        chk("rst-in-wait r_en", 32'(r_en_a), 32'd1);
        step();
        chk("rst-in-wait r_addr", 32'(r_addr_a), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_a_zero("async reset");
        sa = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("after reset r_done", 32'(r_done_a), 32'd0);
            chk("after reset dout_vld", 32'(dout_vld_a), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
